fa_result_checker: RTL and testbench

Hardware response checker for the full-adder datapath: it consumes `{A, B, C, S, Cy}` sample vectors at the DUT's output side and checks each one against the full-adder truth table. It counts vectors and mismatches, and optionally captures the first failing vector. It sits downstream of the full-adder DUT and lets us run self-checking regressions and on-board tests without reading `$monitor` logs.

---
 rtl/fa_result_checker.sv | 155 +++++++++++++++
 tb/tb_fa_result_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fa_result_checker.sv
// Full-adder response checker: compares {a,b,c,s,cy} samples against the truth table, counts vectors/mismatches.
// Define FA_CHK_FIRST_FAIL_EN to build first-failing-vector capture; otherwise fail_idx/fail_vec read as 0.
module fa_result_checker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             s,
    input  logic             cy,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sat,
    output logic [CNT_W-1:0] fail_idx,
    output logic [4:0]       fail_vec
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             sat_q,     sat_d;
    logic             pass_q,    pass_d;

    logic exp_s;
    logic exp_cy;
    logic mismatch;
    logic accept;

    always_comb begin
        exp_s    = a ^ b ^ c;
        exp_cy   = (a & b) | (a & c) | (b & c);
        mismatch = (s != exp_s) || (cy != exp_cy);
        accept   = in_valid && (state_q == ST_RUN);
    end

    // start has priority over a same-cycle accept: the vector is dropped and the session reopens.
    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        sat_d     = sat_q;
        pass_d    = pass_q;

        if (start) begin
            state_d   = ST_RUN;
            vec_cnt_d = '0;
            err_cnt_d = '0;
            sat_d     = 1'b0;
            pass_d    = 1'b0;
        end else if (accept) begin
            if (vec_cnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                vec_cnt_d = vec_cnt_q + CNT_ONE;
            end

            if (mismatch) begin
                if (err_cnt_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
            end

            if (in_last) begin
                state_d = ST_DONE;
                pass_d  = (err_cnt_d == '0);
            end
        end else if ((state_q != ST_IDLE) && (state_q != ST_RUN) && (state_q != ST_DONE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            sat_q     <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            sat_q     <= sat_d;
            pass_q    <= pass_d;
        end
    end

`ifdef FA_CHK_FIRST_FAIL_EN
    logic             fail_seen_q, fail_seen_d;
    logic [CNT_W-1:0] fail_idx_q,  fail_idx_d;
    logic [4:0]       fail_vec_q,  fail_vec_d;

    // fail_idx records the pre-increment count, i.e. the 0-based index of the failing vector.
    always_comb begin
        fail_seen_d = fail_seen_q;
        fail_idx_d  = fail_idx_q;
        fail_vec_d  = fail_vec_q;

        if (start) begin
            fail_seen_d = 1'b0;
            fail_idx_d  = '0;
            fail_vec_d  = '0;
        end else if (accept && mismatch && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_idx_d  = vec_cnt_q;
            fail_vec_d  = {a, b, c, s, cy};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen_q <= 1'b0;
            fail_idx_q  <= '0;
            fail_vec_q  <= '0;
        end else begin
            fail_seen_q <= fail_seen_d;
            fail_idx_q  <= fail_idx_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign fail_idx = fail_idx_q;
    assign fail_vec = fail_vec_q;
`else
    assign fail_idx = '0;
    assign fail_vec = '0;
`endif

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign vec_cnt  = vec_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_fa_result_checker.sv
// Directed bench for fa_result_checker: an 8-bit instance plus a CNT_W=3 instance sharing the same stimulus.
module tb_fa_result_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, s = 1'b0, cy = 1'b0;

    logic       in_ready, busy, done, pass, sat;
    logic [7:0] vec_cnt, err_cnt, fail_idx;
    logic [4:0] fail_vec;

    logic       in_ready3, busy3, done3, pass3, sat3;
    logic [2:0] vec_cnt3, err_cnt3, fail_idx3;
    logic [4:0] fail_vec3;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

`ifdef FA_CHK_FIRST_FAIL_EN
    localparam logic [7:0] EXP_FIDX = 8'd3;
    localparam logic [4:0] EXP_FVEC = 5'b01111;
    localparam logic [7:0] EXP_FIDX_RST = 8'd1;
`else
    localparam logic [7:0] EXP_FIDX = 8'd0;
    localparam logic [4:0] EXP_FVEC = 5'b00000;
    localparam logic [7:0] EXP_FIDX_RST = 8'd0;
`endif

    fa_result_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .a(a), .b(b), .c(c), .s(s), .cy(cy),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .sat(sat), .fail_idx(fail_idx), .fail_vec(fail_vec)
    );

    fa_result_checker #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready3),
        .in_last(in_last), .a(a), .b(b), .c(c), .s(s), .cy(cy),
        .busy(busy3), .done(done3), .pass(pass3), .vec_cnt(vec_cnt3), .err_cnt(err_cnt3),
        .sat(sat3), .fail_idx(fail_idx3), .fail_vec(fail_vec3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic s;
        logic cy;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic va, input logic vb, input logic vc,
                        input logic vs, input logic vcy, input logic last);
        in_valid = 1'b1;
        a = va; b = vb; c = vc; s = vs; cy = vcy;
        in_last = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_busy"},     {31'b0, busy},     32'd0);
        check({tag, "_done"},     {31'b0, done},     32'd0);
        check({tag, "_pass"},     {31'b0, pass},     32'd0);
        check({tag, "_sat"},      {31'b0, sat},      32'd0);
        check({tag, "_vec_cnt"},  {24'b0, vec_cnt},  32'd0);
        check({tag, "_err_cnt"},  {24'b0, err_cnt},  32'd0);
        check({tag, "_fail_idx"}, {24'b0, fail_idx}, 32'd0);
        check({tag, "_fail_vec"}, {27'b0, fail_vec}, 32'd0);
    endtask

    task automatic basic_pass(input string tag);
        pulse_start();
        check({tag, "_start_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_start_busy"},  {31'b0, busy},     32'd1);
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].cy, (i == 7));
            check($sformatf("%s_vec_cnt_%0d", tag, i), {24'b0, vec_cnt}, 32'(i + 1));
            check($sformatf("%s_err_cnt_%0d", tag, i), {24'b0, err_cnt}, 32'd0);
        end
        check({tag, "_done"},    {31'b0, done},     32'd1);
        check({tag, "_pass"},    {31'b0, pass},     32'd1);
        check({tag, "_sat"},     {31'b0, sat},      32'd0);
        check({tag, "_busy"},    {31'b0, busy},     32'd0);
        check({tag, "_ready"},   {31'b0, in_ready}, 32'd0);
        check({tag, "_fidx"},    {24'b0, fail_idx}, 32'd0);
    endtask

    initial begin
        // hand-derived full-adder truth table {a,b,c} -> {s,cy}
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // IDLE gating with bad data
        for (int i = 0; i < 2; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("idle_vec_cnt", {24'b0, vec_cnt}, 32'd0);
        check("idle_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("idle_ready",   {31'b0, in_ready}, 32'd0);
        check("idle_done",    {31'b0, done}, 32'd0);

        basic_pass("basic");

        // single/double failure
        pulse_start();
        check("f_cleared_pass", {31'b0, pass}, 32'd0);
        check("f_cleared_done", {31'b0, done}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3)      send(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            else if (i == 6) send(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            else             send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].cy, (i == 7));
            if (i == 3) begin
                check("f_err_after3",  {24'b0, err_cnt},  32'd1);
                check("f_fidx_after3", {24'b0, fail_idx}, {24'b0, EXP_FIDX});
                check("f_fvec_after3", {27'b0, fail_vec}, {27'b0, EXP_FVEC});
            end
        end
        check("f_done",     {31'b0, done},     32'd1);
        check("f_pass",     {31'b0, pass},     32'd0);
        check("f_vec_cnt",  {24'b0, vec_cnt},  32'd8);
        check("f_err_cnt",  {24'b0, err_cnt},  32'd2);
        check("f_fail_idx", {24'b0, fail_idx}, {24'b0, EXP_FIDX});
        check("f_fail_vec", {27'b0, fail_vec}, {27'b0, EXP_FVEC});

        // DONE gating, then restart clears
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("done_gate_vec",   {24'b0, vec_cnt}, 32'd8);
        check("done_gate_err",   {24'b0, err_cnt}, 32'd2);
        check("done_gate_ready", {31'b0, in_ready}, 32'd0);
        check("done_gate_done",  {31'b0, done}, 32'd1);
        pulse_start();
        check("restart_vec",  {24'b0, vec_cnt},  32'd0);
        check("restart_err",  {24'b0, err_cnt},  32'd0);
        check("restart_busy", {31'b0, busy},     32'd1);
        check("restart_fidx", {24'b0, fail_idx}, 32'd0);
        check("restart_fvec", {27'b0, fail_vec}, 32'd0);
        check("restart_pass", {31'b0, pass},     32'd0);

        // start beats a same-cycle bad accept
        send(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].s, tbl[0].cy, 1'b0);
        send(tbl[1].a, tbl[1].b, tbl[1].c, tbl[1].s, tbl[1].cy, 1'b0);
        check("prio_pre_vec", {24'b0, vec_cnt}, 32'd2);
        start = 1'b1;
        send(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        check("prio_vec",  {24'b0, vec_cnt}, 32'd0);
        check("prio_err",  {24'b0, err_cnt}, 32'd0);
        check("prio_busy", {31'b0, busy},    32'd1);
        check("prio_done", {31'b0, done},    32'd0);
        check("prio_fidx", {24'b0, fail_idx}, 32'd0);

        // asynchronous reset mid-session
        pulse_start();
        send(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].s, tbl[0].cy, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(tbl[2].a, tbl[2].b, tbl[2].c, tbl[2].s, tbl[2].cy, 1'b0);
        send(tbl[3].a, tbl[3].b, tbl[3].c, tbl[3].s, tbl[3].cy, 1'b0);
        check("mid_vec",  {24'b0, vec_cnt},  32'd4);
        check("mid_err",  {24'b0, err_cnt},  32'd1);
        check("mid_fidx", {24'b0, fail_idx}, {24'b0, EXP_FIDX_RST});
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        basic_pass("post_rst");

        // saturation on the CNT_W=3 instance
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            send(tbl[i % 8].a, tbl[i % 8].b, tbl[i % 8].c, tbl[i % 8].s, tbl[i % 8].cy, (i == 8));
            if (i == 6) begin
                check("sat3_vec_at7", {29'b0, vec_cnt3}, 32'd7);
                check("sat3_flag_at7", {31'b0, sat3}, 32'd0);
            end
            if (i == 7) begin
                check("sat3_vec_at8", {29'b0, vec_cnt3}, 32'd7);
                check("sat3_flag_at8", {31'b0, sat3}, 32'd1);
            end
        end
        check("sat3_vec",  {29'b0, vec_cnt3}, 32'd7);
        check("sat3_sat",  {31'b0, sat3},     32'd1);
        check("sat3_pass", {31'b0, pass3},    32'd1);
        check("sat3_done", {31'b0, done3},    32'd1);
        check("sat3_err",  {29'b0, err_cnt3}, 32'd0);
        check("sat8_vec",  {24'b0, vec_cnt},  32'd9);
        check("sat8_sat",  {31'b0, sat},      32'd0);
        check("sat8_pass", {31'b0, pass},     32'd1);

        pulse_start();
        check("sat3_clear", {31'b0, sat3}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
